// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise opcode 2 completes as illegal.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [1:0]       state_dbg
);
    // Handshake: a request transfers on an edge where in_valid && in_ready;
    // a result transfers on an edge where out_valid && out_ready.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
`ifdef SEQ_ALU_MUL_EN
        S_MUL_BUSY = 2'd1,
`endif
        S_DONE     = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd2;
`endif
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;

    state_t state, next_state;

    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic [SHW-1:0]   sh;
    logic [SHW:0]     rot_left;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH:0]   lsr_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    assign sh       = b[SHW-1:0];
    assign rot_left = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign add_ext  = {1'b0, a} + {1'b0, b};
    assign sub_res  = a - b;
    // Carry bit rides in the extra position of each extended shift.
    assign lsl_ext  = {1'b0, a} << sh;
    assign lsr_ext  = {a, 1'b0} >> sh;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_c   = (a >= b);
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  alu_res = a | b;
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_LSL: begin
                alu_res = lsl_ext[WIDTH-1:0];
                alu_c   = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_res = lsr_ext[WIDTH:1];
                alu_c   = lsr_ext[0];
            end
            OP_ROR: begin
                alu_res = (a >> sh) | (a << rot_left);
                alu_c   = alu_res[WIDTH-1];
            end
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};

`ifdef SEQ_ALU_MUL_EN
    // acc holds {partial high, remaining multiplier bits / product low}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [SHW:0]       cnt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               mul_last;
    logic               is_mul;

    assign is_mul   = (opcode == OP_MUL);
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign mul_last = (cnt == (SHW+1)'(WIDTH-1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    next_state = is_mul ? S_MUL_BUSY : S_DONE;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_MUL_BUSY: if (mul_last) next_state = S_DONE;
`endif
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
`ifdef SEQ_ALU_MUL_EN
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                        if (is_mul) begin
                            acc   <= {{WIDTH{1'b0}}, b};
                            mcand <= a;
                            cnt   <= '0;
                        end else begin
                            result_q <= alu_res;
                            flags_q  <= alu_flags;
                        end
`else
                        result_q <= alu_res;
                        flags_q  <= alu_flags;
`endif
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL_BUSY: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (mul_last) begin
                        result_q <= mul_next[WIDTH-1:0];
                        flags_q  <= {mul_next[WIDTH-1], mul_next[WIDTH-1:0] == '0,
                                     1'b0, |mul_next[2*WIDTH-1:WIDTH]};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner vectors plus random ops against an independent model.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [1:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_f_q[$];

  int vectors = 0;
  int miscompares = 0;

`ifdef SEQ_ALU_MUL_EN
  localparam int MUL_LAT = W;
`else
  localparam int MUL_LAT = 0;
`endif

  seq_alu #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_f_q.delete();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, 32'(flags), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // independent reference model
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [3:0] f);
    logic c, v;
    longint sx, sy, s;
    logic [63:0] p;
    int sh;
    longint lim_hi, lim_lo;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    sh = int'(y[4:0]);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      4'd0: begin
        p = {32'b0, x} + {32'b0, y};
        r = p[31:0];
        c = p[32];
        s = sx + sy;
        v = (s > lim_hi) || (s < lim_lo);
      end
      4'd1: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > lim_hi) || (s < lim_lo);
      end
`ifdef SEQ_ALU_MUL_EN
      4'd2: begin
        p = {32'b0, x} * {32'b0, y};
        r = p[31:0];
        v = |p[63:32];
      end
`endif
      4'd3: r = x | y;
      4'd4: r = x & y;
      4'd5: r = x ^ y;
      4'd6: begin
        r = x;
        for (int i = 0; i < sh; i++) begin c = r[31]; r = {r[30:0], 1'b0}; end
      end
      4'd7: begin
        r = x;
        for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[31:1]}; end
      end
      4'd8: begin
        r = x;
        for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
        c = r[31];
      end
      default: r = '0;
    endcase
    f = {r[31], r == '0, c, v};
  endfunction

  // driver: present a request, wait for accept, push expectation, then scramble inputs
  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic [3:0] ef);
    int n;
    opcode = op;
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(er);
    exp_f_q.push_back(ef);
    in_valid = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    a = $urandom;
    b = $urandom;
  endtask

  // wait for the result, optionally stall the consumer, then pop and compare
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int n;
    int ready_seen;
    logic [W-1:0] er;
    logic [3:0] ef;
    n = 0;
    ready_seen = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) ready_seen++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid || exp_q.size() == 0) begin
      check({tag, "_out_timeout"}, 32'(out_valid), 32'd1);
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(exp_f_q.pop_front());
      end
      return;
    end
    er = exp_q.pop_front();
    ef = exp_f_q.pop_front();
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (n > 0) check({tag, "_busy_in_ready"}, 32'(ready_seen), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      opcode = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      check({tag, "_hold_result"}, result, er);
      check({tag, "_hold_flags"}, 32'(flags), 32'(ef));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    check({tag, "_result"}, result, er);
    check({tag, "_flags"}, 32'(flags), 32'(ef));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] r;
    logic [3:0]   f;
    logic [3:0]   op;
    logic [W-1:0] av, bv;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opcode = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    issue(4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
    collect("add_ovf", 0, 0);
    issue(4'd1, 32'd5, 32'd5, 32'h0, 4'b0110);
    collect("sub_eq", 0, 0);
    issue(4'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b1000);
    collect("sub_borrow", 0, 0);
`ifdef SEQ_ALU_MUL_EN
    issue(4'd2, 32'h00010000, 32'h00010000, 32'h0, 4'b0101);
`else
    issue(4'd2, 32'h00010000, 32'h00010000, 32'h0, 4'b0100);
`endif
    collect("mul_ovf", MUL_LAT, 0);
    issue(4'd8, 32'h00000001, 32'd1, 32'h80000000, 4'b1010);
    collect("ror", 0, 0);
    issue(4'd6, 32'h80000001, 32'd1, 32'h00000002, 4'b0010);
    collect("lsl", 0, 0);
    issue(4'd7, 32'h00000010, 32'd0, 32'h00000010, 4'b0000);
    collect("lsr0", 0, 0);
    issue(4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h0, 4'b0100);
    collect("illegal", 0, 0);
    issue(4'd5, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 4'b1000);
    collect("backpressure", 0, 5);

    // reset while a result is waiting in DONE
    issue(4'd5, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 4'b1000);
    do_reset("reset_done");
`ifdef SEQ_ALU_MUL_EN
    issue(4'd2, 32'd3, 32'd5, 32'd15, 4'b0000);
    repeat (9) @(posedge clk);
    #1;
    check("mid_mul_busy", 32'(in_ready), 32'd0);
    do_reset("reset_mul");
`endif
    issue(4'd0, 32'd2, 32'd3, 32'd5, 4'b0000);
    collect("add_after_reset", 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = (i % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      av = $urandom;
      bv = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      model(op, av, bv, r, f);
      issue(op, av, bv, r, f);
      collect("rand", (op == 4'd2) ? MUL_LAT : 0, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
